branch_redirect_sched: RTL and testbench
========================================

Name: branch_redirect_sched

Overview:
Sequencing controller for the ID-stage branch/trap resolution path of the static pipeline CPU. Consumes the 4-bit branch_ena class code and the combinational id_branch decision, then drives PC source select, pipeline stall/bubble/flush controls and a request/acknowledge handshake to CP0 for trap entry (BREAK, SYSCALL, taken TEQ) and ERET. Holds the pipeline on operand hazards into the ID comparator and while older instructions drain before trap entry.

Parameters:
DRAIN_CYCLES, 2, cycles PC/IF-ID are held after trap detection so older EX/MEM/WB instructions retire (1..15).
CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a valid instruction
branch_ena  in  4  class code: 0 JR, 1 J, 2 JAL, 3 BEQ, 4 BNE, 5 BGEZ, 6 JALR, 7 BREAK, 8 SYSCALL, 9 ERET, 10 TEQ, others none
id_branch  in  1  taken/trap decision from the ID comparator
rs_busy  in  1  rs value not yet forwardable to ID
rt_busy  in  1  rt value not yet forwardable to ID
cp0_ack  in  1  CP0 accepted the current trap/ERET request
pc_sel  out  2  0 PC+4, 1 ID target (J/JAL/branch), 2 exception vector, 3 EPC
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID register
id_ex_bubble  out  1  insert NOP into ID/EX
cp0_exc_req  out  1  trap entry request
cp0_eret_req  out  1  ERET request
cp0_cause  out  5  ExcCode: SYSCALL 8, BREAK 9, TEQ 13; 0 otherwise
stall_cnt  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (async, rst_n=0): state RUN, drain counter 0, stall_cnt 0; all outputs 0 (pc_sel=0). Reset mid-trap abandons the request immediately; no ack needed.
- uses_rs: JR, BEQ, BNE, BGEZ, JALR, TEQ. uses_rt: BEQ, BNE, TEQ. hazard = id_valid & ((uses_rs & rs_busy) | (uses_rt & rt_busy)).
- id_valid=0: branch_ena and id_branch ignored.
- RUN, priority hazard > trap/ERET > branch:
  - hazard: pc_stall=1, if_id_stall=1, id_ex_bubble=1, pc_sel=0; stall_cnt+1 (saturates at all ones); stay RUN.
  - trap = BREAK | SYSCALL | (TEQ & id_branch): latch cause, load drain counter with DRAIN_CYCLES; -> DRAIN. Detection cycle already asserts pc_stall, if_id_stall, id_ex_bubble.
  - ERET: latch, load drain counter; -> DRAIN.
  - JR/J/JAL/JALR, or BEQ/BNE/BGEZ with id_branch=1: pc_sel=1 for that cycle only; delay slot kept (no flush, no stall).
  - otherwise: pc_sel=0, controls 0.
- DRAIN: pc_stall, if_id_stall, id_ex_bubble =1; counter decrements; at 1 -> REQ.
- REQ: stalls held; cp0_exc_req=1 (trap) or cp0_eret_req=1 (ERET) with cp0_cause stable; held until cp0_ack=1 (ack in first REQ cycle accepted); -> REDIRECT next cycle.
- REDIRECT (1 cycle): pc_sel=2 (trap) or 3 (ERET); if_id_flush=1, id_ex_bubble=1, pc_stall=0, req deasserted, cause cleared; -> RUN.
- cp0_ack outside REQ ignored. Inputs ignored outside RUN; trap latency = 1 detect + DRAIN_CYCLES + ack wait + 1 redirect.
- stall_cnt counts only RUN hazard cycles, not DRAIN/REQ.

Decomposition:
- Shared package/header mips_ctrl_pkg: branch_ena class codes, pc_sel codes, ExcCode constants, state encoding (RUN, DRAIN, REQ, REDIRECT).
- Single module; saturating counter inline, no sub-module.

Test Plan:
- BEQ (code 3), id_branch=1, no busy -> pc_sel=1 one cycle, all stall/flush 0, stall_cnt 0.
- BNE with rt_busy=1 for 3 cycles, then clear, id_branch=1 -> 3 cycles pc_stall/if_id_stall/id_ex_bubble=1, stall_cnt=3, then pc_sel=1.
- SYSCALL, DRAIN_CYCLES=2, cp0_ack after 2 REQ cycles -> stalls 3 cycles, cp0_exc_req 2 cycles with cause=8, then pc_sel=2 + if_id_flush for 1 cycle.
- TEQ with id_branch=0 -> no trap, controls 0; id_branch=1 -> cause=13 trap sequence; BREAK -> cause=9.
- ERET, cp0_ack same cycle as first request -> cp0_eret_req 1 cycle, then pc_sel=3 + flush.
- rst_n low during REQ -> all outputs 0 immediately; after release, J gives pc_sel=1; CNT_W=2 with 5 hazard cycles -> stall_cnt=3.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared branch/trap control codes for the ID-stage sequencer
package mips_ctrl_pkg;

    localparam logic [3:0] BR_JR      = 4'd0;
    localparam logic [3:0] BR_J       = 4'd1;
    localparam logic [3:0] BR_JAL     = 4'd2;
    localparam logic [3:0] BR_BEQ     = 4'd3;
    localparam logic [3:0] BR_BNE     = 4'd4;
    localparam logic [3:0] BR_BGEZ    = 4'd5;
    localparam logic [3:0] BR_JALR    = 4'd6;
    localparam logic [3:0] BR_BREAK   = 4'd7;
    localparam logic [3:0] BR_SYSCALL = 4'd8;
    localparam logic [3:0] BR_ERET    = 4'd9;
    localparam logic [3:0] BR_TEQ     = 4'd10;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_EXC    = 2'd2;
    localparam logic [1:0] PC_EPC    = 2'd3;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REQ      = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    function automatic logic uses_rs(input logic [3:0] ena);
        return (ena == BR_JR) || (ena == BR_BEQ) || (ena == BR_BNE) ||
               (ena == BR_BGEZ) || (ena == BR_JALR) || (ena == BR_TEQ);
    endfunction

    function automatic logic uses_rt(input logic [3:0] ena);
        return (ena == BR_BEQ) || (ena == BR_BNE) || (ena == BR_TEQ);
    endfunction

endpackage

// File: rtl/branch_redirect_sched.sv
// rtl/branch_redirect_sched.sv - ID-stage branch/trap sequencer with CP0 handshake
module branch_redirect_sched
    import mips_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       branch_ena,
    input  logic             id_branch,
    input  logic             rs_busy,
    input  logic             rt_busy,
    input  logic             cp0_ack,
    output logic [1:0]       pc_sel,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             cp0_exc_req,
    output logic             cp0_eret_req,
    output logic [4:0]       cp0_cause,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [4:0]       cause_q, cause_d;
    logic             eret_q, eret_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard, is_trap, is_eret, is_jump;

    always_comb begin
        hazard  = id_valid & ((uses_rs(branch_ena) & rs_busy) |
                              (uses_rt(branch_ena) & rt_busy));
        is_trap = id_valid & ((branch_ena == BR_BREAK) || (branch_ena == BR_SYSCALL) ||
                              ((branch_ena == BR_TEQ) && id_branch));
        is_eret = id_valid & (branch_ena == BR_ERET);
        is_jump = id_valid & ((branch_ena == BR_JR) || (branch_ena == BR_J) ||
                              (branch_ena == BR_JAL) || (branch_ena == BR_JALR) ||
                              (((branch_ena == BR_BEQ) || (branch_ena == BR_BNE) ||
                                (branch_ena == BR_BGEZ)) && id_branch));
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        cause_d      = cause_q;
        eret_d       = eret_q;
        stall_cnt_d  = stall_cnt_q;
        pc_sel       = PC_SEQ;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        cp0_exc_req  = 1'b0;
        cp0_eret_req = 1'b0;
        cp0_cause    = EXC_NONE;

        case (state_q)
            ST_RUN: begin
                if (hazard) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end else if (is_trap || is_eret) begin
                    // Freeze fetch in the detect cycle so the trapping instruction stays in ID
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    drain_d      = DRAIN_LOAD;
                    eret_d       = is_eret;
                    if (is_eret)                        cause_d = EXC_NONE;
                    else if (branch_ena == BR_SYSCALL)  cause_d = EXC_SYSCALL;
                    else if (branch_ena == BR_BREAK)    cause_d = EXC_BREAK;
                    else                                cause_d = EXC_TEQ;
                    state_d = ST_DRAIN;
                end else if (is_jump) begin
                    pc_sel = PC_TARGET;
                end
            end
            ST_DRAIN: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
                drain_d      = drain_q - 4'd1;
                if (drain_q <= 4'd1) state_d = ST_REQ;
            end
            ST_REQ: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
                cp0_eret_req = eret_q;
                cp0_exc_req  = ~eret_q;
                cp0_cause    = cause_q;
                if (cp0_ack) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_sel       = eret_q ? PC_EPC : PC_EXC;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                cause_d      = EXC_NONE;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_q     <= 4'd0;
            cause_q     <= EXC_NONE;
            eret_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cause_q     <= cause_d;
            eret_q      <= eret_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_branch_redirect_sched.sv
// tb/tb_branch_redirect_sched.sv - directed self-checking bench for branch_redirect_sched
module tb_branch_redirect_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  branch_ena = 4'd15;
    logic        id_branch = 1'b0;
    logic        rs_busy = 1'b0;
    logic        rt_busy = 1'b0;
    logic        cp0_ack = 1'b0;

    logic [1:0]  pc_sel;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, cp0_exc_req, cp0_eret_req;
    logic [4:0]  cp0_cause;
    logic [15:0] stall_cnt;

    logic [1:0]  s_pc_sel;
    logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_bubble, s_exc, s_eret;
    logic [4:0]  s_cause;
    logic [1:0]  s_stall_cnt;

    logic [7:0]  ctl;
    int          checks = 0;
    int          errors = 0;

    assign ctl = {pc_sel, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, cp0_exc_req, cp0_eret_req};

    always #5 clk = ~clk;

    branch_redirect_sched #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .branch_ena(branch_ena),
        .id_branch(id_branch), .rs_busy(rs_busy), .rt_busy(rt_busy), .cp0_ack(cp0_ack),
        .pc_sel(pc_sel), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .cp0_exc_req(cp0_exc_req),
        .cp0_eret_req(cp0_eret_req), .cp0_cause(cp0_cause), .stall_cnt(stall_cnt)
    );

    branch_redirect_sched #(.DRAIN_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .branch_ena(branch_ena),
        .id_branch(id_branch), .rs_busy(rs_busy), .rt_busy(rt_busy), .cp0_ack(cp0_ack),
        .pc_sel(s_pc_sel), .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .cp0_exc_req(s_exc),
        .cp0_eret_req(s_eret), .cp0_cause(s_cause), .stall_cnt(s_stall_cnt)
    );

    task automatic drive(input logic v, input logic [3:0] e, input logic b,
                         input logic rs, input logic rt, input logic ack);
        @(negedge clk);
        id_valid = v; branch_ena = e; id_branch = b;
        rs_busy = rs; rt_busy = rt; cp0_ack = ack;
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (ctl !== 8'h00 || cp0_cause !== 5'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset: ctl=%b cause=%0d cnt=%0d, expected 0", ctl, cp0_cause, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_beq_taken;
        drive(1, 4'd3, 1, 0, 0, 0);
        checks++;
        if (ctl !== {2'd1, 6'b000000} || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL beq_taken: ctl=%b cnt=%0d, expected ctl=01000000 cnt=0", ctl, stall_cnt);
        end
        drive(0, 4'd3, 1, 1, 1, 0);
        checks++;
        if (ctl !== 8'h00) begin
            errors++;
            $display("FAIL invalid_ignored: ctl=%b, expected 00000000", ctl);
        end
    endtask

    task automatic test_bne_hazard;
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'd4, 1, 0, 1, 0);
            checks++;
            if (ctl !== {2'd0, 6'b110100} || stall_cnt !== 16'(k)) begin
                errors++;
                $display("FAIL bne_hazard[%0d]: ctl=%b cnt=%0d, expected ctl=00110100 cnt=%0d",
                         k, ctl, stall_cnt, k);
            end
        end
        drive(1, 4'd4, 1, 0, 0, 0);
        checks++;
        if (ctl !== {2'd1, 6'b000000} || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bne_resolve: ctl=%b cnt=%0d, expected ctl=01000000 cnt=3", ctl, stall_cnt);
        end
    endtask

    task automatic test_trap(input logic [3:0] ena, input logic br, input logic eret,
                             input logic [4:0] cause, input int ack_wait);
        logic [7:0] req_ctl, redir_ctl;
        req_ctl   = eret ? {2'd0, 6'b110101} : {2'd0, 6'b110110};
        redir_ctl = eret ? {2'd3, 6'b001100} : {2'd2, 6'b001100};
        drive(1, ena, br, 0, 0, 0);
        checks++;
        if (ctl !== {2'd0, 6'b110100}) begin
            errors++;
            $display("FAIL trap_detect(%0d): ctl=%b, expected 00110100", ena, ctl);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 4'd1, 1, 1, 1, 1);
            checks++;
            if (ctl !== {2'd0, 6'b110100} || cp0_cause !== 5'd0) begin
                errors++;
                $display("FAIL trap_drain(%0d)[%0d]: ctl=%b cause=%0d, expected 00110100 cause=0",
                         ena, k, ctl, cp0_cause);
            end
        end
        for (int k = 0; k < ack_wait; k++) begin
            drive(0, 4'd15, 0, 0, 0, (k == ack_wait - 1));
            checks++;
            if (ctl !== req_ctl || cp0_cause !== cause) begin
                errors++;
                $display("FAIL trap_req(%0d)[%0d]: ctl=%b cause=%0d, expected %b cause=%0d",
                         ena, k, ctl, cp0_cause, req_ctl, cause);
            end
        end
        drive(0, 4'd15, 0, 0, 0, 1);
        checks++;
        if (ctl !== redir_ctl || cp0_cause !== 5'd0) begin
            errors++;
            $display("FAIL trap_redirect(%0d): ctl=%b cause=%0d, expected %b cause=0",
                     ena, ctl, cp0_cause, redir_ctl);
        end
        drive(0, 4'd15, 0, 0, 0, 1);
        checks++;
        if (ctl !== 8'h00) begin
            errors++;
            $display("FAIL trap_back_to_run(%0d): ctl=%b, expected 00000000", ena, ctl);
        end
    endtask

    task automatic test_teq_not_taken;
        drive(1, 4'd10, 0, 0, 0, 0);
        checks++;
        if (ctl !== 8'h00) begin
            errors++;
            $display("FAIL teq_not_taken: ctl=%b, expected 00000000", ctl);
        end
        drive(1, 4'd1, 0, 0, 0, 0);
        checks++;
        if (ctl !== {2'd1, 6'b000000}) begin
            errors++;
            $display("FAIL teq_then_j: ctl=%b, expected 01000000", ctl);
        end
    endtask

    task automatic test_reset_mid_req;
        drive(1, 4'd8, 0, 0, 0, 0);
        drive(0, 4'd15, 0, 0, 0, 0);
        drive(0, 4'd15, 0, 0, 0, 0);
        drive(0, 4'd15, 0, 0, 0, 0);
        checks++;
        if (ctl !== {2'd0, 6'b110110}) begin
            errors++;
            $display("FAIL pre_reset_req: ctl=%b, expected 00110110", ctl);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== 8'h00 || cp0_cause !== 5'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_req: ctl=%b cause=%0d cnt=%0d, expected 0", ctl, cp0_cause, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4'd1, 0, 0, 0, 0);
        checks++;
        if (ctl !== {2'd1, 6'b000000}) begin
            errors++;
            $display("FAIL j_after_reset: ctl=%b, expected 01000000", ctl);
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 5; k++) drive(1, 4'd0, 0, 1, 0, 0);
        drive(0, 4'd15, 0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL cnt_wide: got %0d, expected 5", stall_cnt);
        end
        checks++;
        if (s_stall_cnt !== 2'd3) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d, expected 3", s_stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_hazard();
        test_trap(4'd8, 1'b0, 1'b0, 5'd8, 2);
        test_teq_not_taken();
        test_trap(4'd10, 1'b1, 1'b0, 5'd13, 1);
        test_trap(4'd7, 1'b0, 1'b0, 5'd9, 3);
        test_trap(4'd9, 1'b0, 1'b1, 5'd0, 1);
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL cnt_after_traps: got %0d, expected 3", stall_cnt);
        end
        test_reset_mid_req();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
